// File: rtl/ysyx_25060170_trap_seq_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_trap_seq_pkg
// Shared definitions for the machine-mode trap sequencer:
//   - FSM state encoding and the latched trap kind
//   - CSR addresses written by the sequencer (mstatus/mepc/mcause)
//   - cause codes for ecall-from-M and the machine timer interrupt
//   - mstatus bit positions and the two mstatus update helpers
// Optional feature macro (used by the top): YSYX_25060170_TRAP_VEC_EN
// ---------------------------------------------------------------------------
package ysyx_25060170_trap_seq_pkg;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StDrain     = 3'd1,
      StWrMepc    = 3'd2,
      StWrMcause  = 3'd3,
      StWrMstatus = 3'd4,
      StRedirect  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      KindNone = 2'd0,
      KindTrap = 2'd1,
      KindMret = 2'd2,
      KindIrq  = 2'd3
   } kind_e;

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMepc    = 12'h341;
   localparam logic [11:0] CsrMcause  = 12'h342;

   localparam logic [31:0] CauseEcallM = 32'd11;
   localparam logic [31:0] CauseMtimer = 32'h8000_0007;

   localparam int unsigned MstatusMie   = 3;
   localparam int unsigned MstatusMpie  = 7;
   localparam int unsigned MstatusMppLo = 11;
   localparam int unsigned MstatusMppHi = 12;

   // Trap entry: stash MIE into MPIE, mask interrupts, record M as previous mode.
   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
      logic [31:0] r;
      r                           = ms;
      r[MstatusMpie]              = ms[MstatusMie];
      r[MstatusMie]               = 1'b0;
      r[MstatusMppHi:MstatusMppLo] = 2'b11;
      return r;
   endfunction

   // Trap return: restore MIE from MPIE, set MPIE, previous mode stays M.
   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
      logic [31:0] r;
      r                           = ms;
      r[MstatusMie]               = ms[MstatusMpie];
      r[MstatusMpie]              = 1'b1;
      r[MstatusMppHi:MstatusMppLo] = 2'b11;
      return r;
   endfunction

endpackage

// File: rtl/ysyx_25060170_trap_seq.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_trap_seq
// Sequences ecall / mret / machine timer interrupt at instruction boundaries:
// waits for outstanding memory ops, writes mepc/mcause/mstatus through a single
// CSR write port (one CSR per cycle), then redirects fetch and flushes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   retire_valid        instruction boundary this cycle
//   ecall_req/mret_req  retiring instruction is ecall / mret
//   irq_timer           level timer interrupt request (gated by mstatus.MIE)
//   pc_i/next_pc_i      pc of retiring / next instruction
//   pipe_busy           load/store outstanding; sequencer holds in drain
//   mtvec_i/mepc_i/mstatus_i  current CSR values
//   csr_we/csr_waddr/csr_wdata  CSR write port
//   redirect/redirect_pc/flush  fetch redirect and pipeline flush
//   stall_o             freeze IF/ID/EX while a trap is in progress
//
// Macro YSYX_25060170_TRAP_VEC_EN: vectored mtvec (mode 01) for interrupts.
// All outputs are registered: they are decoded from the next state.
// ---------------------------------------------------------------------------
module ysyx_25060170_trap_seq
   import ysyx_25060170_trap_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        retire_valid,
   input  logic        ecall_req,
   input  logic        mret_req,
   input  logic        irq_timer,
   input  logic [31:0] pc_i,
   input  logic [31:0] next_pc_i,
   input  logic        pipe_busy,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   input  logic [31:0] mstatus_i,
   output logic        csr_we,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        stall_o
);

   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] cause_q, cause_d;

   logic        csr_we_d, redirect_d, flush_d, stall_d;
   logic [11:0] csr_waddr_d;
   logic [31:0] csr_wdata_d, redirect_pc_d;
   logic [31:0] trap_base;

   assign trap_base = {mtvec_i[31:2], 2'b00};

   // Next-state and latched trap info.
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      unique case (state_q)
         StIdle: begin
            if (retire_valid) begin
               if (ecall_req) begin
                  state_d = StDrain;
                  kind_d  = KindTrap;
                  epc_d   = pc_i;
                  cause_d = CauseEcallM;
               end else if (mret_req) begin
                  state_d = StDrain;
                  kind_d  = KindMret;
                  epc_d   = '0;
                  cause_d = '0;
               end else if (irq_timer && mstatus_i[MstatusMie]) begin
                  state_d = StDrain;
                  kind_d  = KindIrq;
                  epc_d   = next_pc_i;
                  cause_d = CauseMtimer;
               end
            end
         end
         StDrain: begin
            if (!pipe_busy) begin
               state_d = (kind_q == KindMret) ? StWrMstatus : StWrMepc;
            end
         end
         StWrMepc:    state_d = StWrMcause;
         StWrMcause:  state_d = StWrMstatus;
         StWrMstatus: state_d = StRedirect;
         StRedirect:  state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   // Redirect target for the redirect cycle.
   always_comb begin
      if (kind_d == KindMret) begin
         redirect_pc_d = mepc_i;
      end else begin
         redirect_pc_d = trap_base;
`ifdef YSYX_25060170_TRAP_VEC_EN
         if (kind_d == KindIrq && mtvec_i[1:0] == 2'b01) begin
            redirect_pc_d = trap_base + {cause_d[29:0], 2'b00};
         end
`endif
      end
   end

`ifndef YSYX_25060170_TRAP_VEC_EN
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^mtvec_i[1:0];
`endif

   // Output decode from the next state so the outputs can be registered.
   always_comb begin
      csr_we_d    = 1'b0;
      csr_waddr_d = '0;
      csr_wdata_d = '0;
      redirect_d  = 1'b0;
      flush_d     = 1'b0;
      stall_d     = (state_d != StIdle);
      unique case (state_d)
         StWrMepc: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = CsrMepc;
            csr_wdata_d = epc_d;
         end
         StWrMcause: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = CsrMcause;
            csr_wdata_d = cause_d;
         end
         StWrMstatus: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = CsrMstatus;
            csr_wdata_d = (kind_d == KindMret) ? mstatus_on_mret(mstatus_i)
                                               : mstatus_on_trap(mstatus_i);
         end
         StRedirect: begin
            redirect_d = 1'b1;
            flush_d    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         kind_q      <= KindNone;
         epc_q       <= '0;
         cause_q     <= '0;
         csr_we      <= 1'b0;
         csr_waddr   <= '0;
         csr_wdata   <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         flush       <= 1'b0;
         stall_o     <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= (state_d == StIdle) ? KindNone : kind_d;
         epc_q       <= epc_d;
         cause_q     <= cause_d;
         csr_we      <= csr_we_d;
         csr_waddr   <= csr_waddr_d;
         csr_wdata   <= csr_wdata_d;
         redirect    <= redirect_d;
         redirect_pc <= redirect_d ? redirect_pc_d : 32'h0;
         flush       <= flush_d;
         stall_o     <= stall_d;
      end
   end

endmodule

// File: tb/tb_ysyx_25060170_trap_seq.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25060170_trap_seq
// Directed bench for the trap sequencer. Expected CSR writes and redirects are
// queued when a request is driven and checked as the DUT produces them,
// including the cycle at which each one appears.
// ---------------------------------------------------------------------------
module tb_ysyx_25060170_trap_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        retire_valid, ecall_req, mret_req, irq_timer, pipe_busy;
   logic [31:0] pc_i, next_pc_i, mtvec_i, mepc_i, mstatus_i;
   logic        csr_we, redirect, flush, stall_o;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata, redirect_pc;

   ysyx_25060170_trap_seq dut (
      .clk          (clk),
      .rst          (rst),
      .retire_valid (retire_valid),
      .ecall_req    (ecall_req),
      .mret_req     (mret_req),
      .irq_timer    (irq_timer),
      .pc_i         (pc_i),
      .next_pc_i    (next_pc_i),
      .pipe_busy    (pipe_busy),
      .mtvec_i      (mtvec_i),
      .mepc_i       (mepc_i),
      .mstatus_i    (mstatus_i),
      .csr_we       (csr_we),
      .csr_waddr    (csr_waddr),
      .csr_wdata    (csr_wdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .flush        (flush),
      .stall_o      (stall_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_redir;
      logic [11:0] addr;
      logic [31:0] data;
      int          at;
   } ev_t;

   ev_t sbq[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ms_trap(input logic [31:0] m);
      return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
   endfunction

   function automatic logic [31:0] ms_mret(input logic [31:0] m);
      return (m & ~32'h0000_1888) | 32'h0000_1880 | (m[7] ? 32'h8 : 32'h0);
   endfunction

   // Scoreboard consumer.
   always @(negedge clk) begin
      ev_t e;
      if (csr_we === 1'b1 || redirect === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_event", {62'd0, csr_we, redirect}, 64'd0);
         end else begin
            e = sbq.pop_front();
            if (e.is_redir) begin
               chk("redir_flags", {61'd0, redirect, flush, csr_we}, 64'b110);
               chk("redir_pc", redirect_pc, e.data);
            end else begin
               chk("csr_flags", {61'd0, csr_we, redirect, flush}, 64'b100);
               chk("csr_addr", csr_waddr, e.addr);
               chk("csr_data", csr_wdata, e.data);
            end
            chk("event_cycle", cyc, e.at);
            chk("stall_in_seq", stall_o, 1);
         end
      end
   end

   task automatic push_csr(input logic [11:0] a, input logic [31:0] d, input int at);
      ev_t e;
      e.is_redir = 1'b0; e.addr = a; e.data = d; e.at = at;
      sbq.push_back(e);
   endtask

   task automatic push_redir(input logic [31:0] pc, input int at);
      ev_t e;
      e.is_redir = 1'b1; e.addr = '0; e.data = pc; e.at = at;
      sbq.push_back(e);
   endtask

   task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause, input int n,
                            input int drain, input logic [31:0] tgt);
      push_csr(12'h341, epc, n + 2 + drain);
      push_csr(12'h342, cause, n + 3 + drain);
      push_csr(12'h300, ms_trap(mstatus_i), n + 4 + drain);
      push_redir(tgt, n + 5 + drain);
   endtask

   // One-cycle retire; returns the acceptance cycle number.
   task automatic retire(input bit ec, input bit mr, input bit irq, input logic [31:0] pc,
                         input logic [31:0] npc, output int n);
      @(posedge clk); #1;
      retire_valid = 1'b1; ecall_req = ec; mret_req = mr; irq_timer = irq;
      pc_i = pc; next_pc_i = npc;
      n = cyc;
      @(posedge clk); #1;
      retire_valid = 1'b0; ecall_req = 1'b0; mret_req = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 40 && sbq.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      chk({tag, "_pending"}, sbq.size(), 0);
      @(negedge clk);
      chk({tag, "_back_idle"}, stall_o, 0);
   endtask

   int n;
   logic [31:0] vec_tgt;

   initial begin
      rst = 1'b1; retire_valid = 0; ecall_req = 0; mret_req = 0; irq_timer = 0;
      pipe_busy = 0; pc_i = 0; next_pc_i = 0; mepc_i = 0; mstatus_i = 0;
      mtvec_i = 32'h8000_0100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {csr_we, csr_waddr, csr_wdata, redirect, redirect_pc, flush, stall_o},
          64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // ecall, no drain
      mstatus_i = 32'h0000_0088;
      retire(1, 0, 0, 32'h8000_0010, 32'h8000_0014, n);
      push_trap(32'h8000_0010, 32'd11, n, 0, 32'h8000_0100);
      @(negedge clk);
      chk("ecall_stall_drain", stall_o, 1);
      wait_done("ecall");

      // mret
      mstatus_i = 32'h0000_0080; mepc_i = 32'h8000_0014;
      retire(0, 1, 0, 32'h8000_0050, 32'h8000_0054, n);
      push_csr(12'h300, ms_mret(mstatus_i), n + 2);
      push_redir(32'h8000_0014, n + 3);
      wait_done("mret");

      // timer irq with MIE=1
      mstatus_i = 32'h0000_0008;
      retire(0, 0, 1, 32'h8000_001c, 32'h8000_0020, n);
      push_trap(32'h8000_0020, 32'h8000_0007, n, 0, 32'h8000_0100);
      wait_done("irq");
      irq_timer = 1'b0;

      // timer irq with MIE=0: must not be taken
      mstatus_i = 32'h0000_0080;
      retire(0, 0, 1, 32'h8000_0030, 32'h8000_0034, n);
      @(negedge clk);
      chk("irq_masked_stall_a", stall_o, 0);
      @(negedge clk);
      chk("irq_masked_stall_b", stall_o, 0);
      irq_timer = 1'b0;

      // ecall with pipe_busy high for three drain cycles
      mstatus_i = 32'h0000_0008; pipe_busy = 1'b1;
      retire(1, 0, 0, 32'h8000_0040, 32'h8000_0044, n);
      push_trap(32'h8000_0040, 32'd11, n, 3, 32'h8000_0100);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("drain_stall", {stall_o, csr_we}, 2'b10);
      end
      @(posedge clk); #1 pipe_busy = 1'b0;
      wait_done("drain");

      // ecall with irq together: ecall first, irq on next retire
      mstatus_i = 32'h0000_0008;
      retire(1, 0, 1, 32'h8000_0060, 32'h8000_0064, n);
      push_trap(32'h8000_0060, 32'd11, n, 0, 32'h8000_0100);
      wait_done("ecall_irq_first");
      retire(0, 0, 1, 32'h8000_0100, 32'h8000_0104, n);
      push_trap(32'h8000_0104, 32'h8000_0007, n, 0, 32'h8000_0100);
      wait_done("ecall_irq_second");
      irq_timer = 1'b0;

      // reset during WR_MCAUSE
      retire(1, 0, 0, 32'h8000_0070, 32'h8000_0074, n);
      push_csr(12'h341, 32'h8000_0070, n + 2);
      push_csr(12'h342, 32'd11, n + 3);
      @(posedge clk); @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_outputs", {csr_we, csr_waddr, csr_wdata, redirect, redirect_pc, flush, stall_o},
          64'd0);
      chk("rst_mid_pending", sbq.size(), 0);
      @(negedge clk);
      chk("rst_mid_idle", stall_o, 0);

      // vectored mtvec with irq
      mtvec_i = 32'h8000_0101;
`ifdef YSYX_25060170_TRAP_VEC_EN
      vec_tgt = 32'h8000_011C;
`else
      vec_tgt = 32'h8000_0100;
`endif
      retire(0, 0, 1, 32'h8000_0080, 32'h8000_0084, n);
      push_trap(32'h8000_0084, 32'h8000_0007, n, 0, vec_tgt);
      wait_done("vec_irq");
      irq_timer = 1'b0;

      // vectored mtvec with ecall still goes to base
      retire(1, 0, 0, 32'h8000_0090, 32'h8000_0094, n);
      push_trap(32'h8000_0090, 32'd11, n, 0, 32'h8000_0100);
      wait_done("vec_ecall");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_25060170_trap_seq.md
YSYX_25060170_TRAP_SEQ -- requirements
Module: ysyx_25060170_trap_seq

Interface
REQ-001 SHALL: clk  in  1  clock; rst  in  1  reset; reset is rst, synchronous, active-high; clock is clk.
REQ-002 SHALL: retire_valid  in  1  an instruction retires this cycle (instruction boundary).
REQ-003 SHALL: ecall_req / mret_req  in  1 each  the retiring instruction is ecall / mret; each is qualified by retire_valid.
REQ-004 SHALL: irq_timer  in  1  level timer interrupt request.
REQ-005 SHALL: pc_i / next_pc_i  in  32 each  pc of the retiring instruction / pc of the next instruction to execute.
REQ-006 SHALL: pipe_busy  in  1  load/store still outstanding; sequencing waits while high.
REQ-007 SHALL: mtvec_i, mepc_i, mstatus_i  in  32 each  current CSR values.
REQ-008 SHALL: csr_we  out  1; csr_waddr  out  12; csr_wdata  out  32  single CSR write port.
REQ-009 SHALL: redirect  out  1; redirect_pc  out  32; flush  out  1  fetch redirect and pipeline flush.
REQ-010 SHALL: stall_o  out  1  freezes IF/ID/EX while a trap is in progress.

Function
REQ-011 SHALL use FSM states IDLE, DRAIN, WR_MEPC, WR_MCAUSE, WR_MSTATUS, REDIRECT.
REQ-012 SHALL, in IDLE on a cycle with retire_valid=1, accept in priority order: ecall_req (trap), then mret_req, then irq_timer with mstatus_i[3]=1 (interrupt); go to DRAIN; otherwise stay in IDLE.
REQ-013 SHALL latch into registers at acceptance: kind (trap/mret/irq), epc (pc_i for ecall, next_pc_i for irq), cause (11 for ecall, 0x80000007 for irq).
REQ-014 SHALL hold DRAIN while pipe_busy=1; on pipe_busy=0 go to WR_MEPC (trap/irq) or WR_MSTATUS (mret).
REQ-015 SHALL make each WR_* state exactly one cycle with csr_we=1: WR_MEPC addr 0x341, data epc; WR_MCAUSE addr 0x342, data cause; WR_MSTATUS addr 0x300.
REQ-016 SHALL set mstatus data for trap/irq to mstatus_i with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11; for mret: MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
REQ-017 SHALL make the sequence WR_MEPC->WR_MCAUSE->WR_MSTATUS->REDIRECT for trap/irq, and WR_MSTATUS->REDIRECT for mret.
REQ-018 SHALL in REDIRECT assert redirect=1 and flush=1 for one cycle; redirect_pc = mtvec_i & ~3 (trap/irq) or mepc_i (mret); then return to IDLE.
REQ-019 SHALL assert stall_o=1 in every state except IDLE; csr_we, redirect and flush SHALL be 0 outside their states, with redirect_pc, csr_waddr and csr_wdata at 0.
REQ-020 SHALL ignore all requests while not in IDLE; a level irq_timer still high is re-evaluated at the next IDLE retire.
REQ-021 SHALL give minimum latency, with pipe_busy=0: acceptance at cycle N, redirect at N+5 (trap/irq) or N+3 (mret).
REQ-022 SHALL, on simultaneous ecall_req and irq_timer, take ecall; the irq stays pending.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, go to IDLE, clear kind/epc/cause, and drive all outputs 0, including mid-sequence; partially written CSRs are not rolled back.

Configuration
REQ-024 SHALL, with YSYX_25060170_TRAP_VEC_EN defined and mtvec_i[1:0]=2'b01 for an irq, set redirect_pc = (mtvec_i & ~3) + 4*cause[30:0]; without the macro, or for synchronous traps, redirect_pc = mtvec_i & ~3.

Structure
REQ-025 SHALL place the state encoding, CSR addresses (0x300/0x341/0x342), cause codes and mstatus bit positions in the shared define file.
REQ-026 SHALL be a single flat module; no sub-module.

Verification
REQ-027 SHALL cover: ecall at pc 0x80000010, mtvec 0x80000100, pipe_busy=0 -> writes 0x341=0x80000010, 0x342=11, 0x300 MIE=0; redirect to 0x80000100 at N+5.
REQ-028 SHALL cover: mret with mepc 0x80000014 and mstatus MPIE=1 -> 0x300 with MIE=1; redirect to 0x80000014 at N+3.
REQ-029 SHALL cover: irq_timer=1, MIE=1, next_pc 0x80000020 -> mepc 0x80000020, mcause 0x80000007; with MIE=0 -> no acceptance.
REQ-030 SHALL cover: ecall with pipe_busy high for 3 cycles -> DRAIN held 3 cycles, stall_o high throughout, redirect at N+8.
REQ-031 SHALL cover: ecall and irq together -> ecall taken, then irq taken on the first retire after return to IDLE.
REQ-032 SHALL cover: rst pulsed in WR_MCAUSE -> next cycle IDLE, all outputs 0; with VEC_EN, mtvec 0x80000101 and irq -> redirect 0x8000011C.
